// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding and flag check for the SAR search controller
package sar_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TEST   = 2'd1;
  localparam logic [1:0] ST_VERIFY = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic logic flags_onehot(input logic g, input logic l, input logic e);
    return (g ^ l ^ e) & ~(g & l & e);
  endfunction
endpackage

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: binary-searches a comparator's hidden operand by driving trial values
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cmp_greater,
  input  logic         cmp_lesser,
  input  logic         cmp_equal,
  output logic [N-1:0] trial,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         found,
  output logic         error
);
  localparam int PW = $clog2(N);

  logic [1:0]    st_q, st_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  acc_q, acc_d, trial_q, trial_d, result_q, result_d, bit_m;
  logic          busy_q, busy_d, done_q, done_d, found_q, found_d, error_q, error_d, ok;

  assign ok    = flags_onehot(cmp_greater, cmp_lesser, cmp_equal);
  assign bit_m = {{(N-1){1'b0}}, 1'b1} << ptr_q;

  always_comb begin
    st_d     = st_q;
    ptr_d    = ptr_q;
    acc_d    = acc_q;
    result_d = result_q;
    found_d  = found_q;
    error_d  = error_q;
    case (st_q)
      ST_IDLE: if (start) begin
        acc_d   = '0;
        found_d = 1'b0;
        error_d = 1'b0;
        ptr_d   = PW'(N - 1);
        st_d    = ST_TEST;
      end
      ST_TEST: if (!ok || cmp_equal) begin
        result_d = trial_q;
        error_d  = !ok;
        found_d  = ok;
        st_d     = ST_DONE;
      end else begin
        acc_d = cmp_greater ? (acc_q | bit_m) : (acc_q & ~bit_m);
        st_d  = (ptr_q == '0) ? ST_VERIFY : ST_TEST;
        ptr_d = (ptr_q == '0) ? ptr_q : ptr_q - 1'b1;
      end
      ST_VERIFY: begin
        found_d  = ok && cmp_equal;
        error_d  = !(ok && cmp_equal);
        result_d = acc_q;
        st_d     = ST_DONE;
      end
      default: st_d = ST_IDLE;
    endcase
    done_d  = st_d == ST_DONE;
    busy_d  = st_d != ST_IDLE;
    // trial tracks the next state so the comparator sees it for the whole TEST/VERIFY cycle
    trial_d = (st_d == ST_TEST)   ? (acc_d | ({{(N-1){1'b0}}, 1'b1} << ptr_d)) :
              (st_d == ST_VERIFY) ? acc_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= ST_IDLE;
      ptr_q    <= PW'(N - 1);
      acc_q    <= '0;
      trial_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      ptr_q    <= ptr_d;
      acc_q    <= acc_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      error_q  <= error_d;
    end
  end

  assign trial  = trial_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign found  = found_q;
  assign error  = error_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: scoreboard bench pairing the controller with a behavioural comparator
module tb_sar_search_ctrl;
  logic       clk = 0, rst = 1, start = 0, force_bad = 0;
  logic [7:0] tgt = 0;
  logic       cmp_greater, cmp_lesser, cmp_equal, busy, done, found, error;
  logic [7:0] trial, result;
  int         total = 0, bad = 0;
  logic [7:0] exp_q[$];

  assign cmp_greater = force_bad ? 1'b1 : (tgt > trial);
  assign cmp_lesser  = force_bad ? 1'b1 : (tgt < trial);
  assign cmp_equal   = force_bad ? 1'b0 : (tgt == trial);

  always #5 clk = ~clk;

  sar_search_ctrl #(.N(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmp_greater(cmp_greater), .cmp_lesser(cmp_lesser), .cmp_equal(cmp_equal),
    .trial(trial), .busy(busy), .done(done), .result(result), .found(found), .error(error)
  );

  task automatic push_list(input logic [7:0] l[$]);
    foreach (l[i]) exp_q.push_back(l[i]);
  endtask

  task automatic push_model(input logic [7:0] t, output int cyc, output logic [7:0] res);
    logic [7:0] a = 0, tr;
    cyc = 0;
    for (int k = 7; k >= 0; k--) begin
      tr = a | (8'd1 << k);
      exp_q.push_back(tr);
      cyc++;
      if (tr == t) begin
        res = tr;
        cyc++;
        return;
      end
      if (t > tr) a = tr;
    end
    exp_q.push_back(a);
    res = a;
    cyc += 2;
  endtask

  task automatic run_search(input string nm, input logic [7:0] t, input logic fb, input logic spam,
                            input int exp_cyc, input logic [7:0] exp_res, input logic exp_f, input logic exp_e);
    logic [7:0] e;
    int c = 1;
    bit fin = 0;
    tgt = t;
    force_bad = fb;
    @(negedge clk) start = 1;
    @(negedge clk) start = spam;
    while (c <= 12 && !fin) begin
      if (done) begin
        fin = 1;
        total++;
        if (c !== exp_cyc || result !== exp_res || found !== exp_f || error !== exp_e || !busy) begin
          bad++;
          $display("FAIL %s done: cyc=%0d res=%h f=%b e=%b busy=%b want cyc=%0d res=%h f=%b e=%b",
                   nm, c, result, found, error, busy, exp_cyc, exp_res, exp_f, exp_e);
        end
        total++;
        if (exp_q.size() != 0) begin
          bad++;
          $display("FAIL %s leftover trials: got %0d want 0", nm, exp_q.size());
          exp_q.delete();
        end
      end else begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (trial !== e || busy !== 1'b1) begin
          bad++;
          $display("FAIL %s trial c%0d: got %h busy=%b want %h busy=1", nm, c, trial, busy, e);
        end
        @(negedge clk);
        c++;
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no done within 12 cycles, want %0d", nm, exp_cyc);
      exp_q.delete();
    end
    @(negedge clk) start = 0;
    force_bad = 0;
    total++;
    if (busy !== 0 || done !== 0 || trial !== 0 || result !== exp_res) begin
      bad++;
      $display("FAIL %s idle: busy=%b done=%b trial=%h res=%h want 0 0 00 %h", nm, busy, done, trial, result, exp_res);
    end
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({trial, busy, done, result, found, error} !== '0) begin
      bad++;
      $display("FAIL reset_state: got %h/%b/%b/%h/%b/%b want all 0", trial, busy, done, result, found, error);
    end
    @(negedge clk) rst = 0;
  endtask

  task automatic test_plan_vectors;
    int c;
    logic [7:0] r;
    push_list('{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5});
    run_search("tgt_a5", 8'hA5, 0, 0, 9, 8'hA5, 1, 0);
    push_list('{8'h80, 8'h40});
    run_search("tgt_40", 8'h40, 0, 0, 3, 8'h40, 1, 0);
    push_list('{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00});
    run_search("tgt_00", 8'h00, 0, 0, 10, 8'h00, 1, 0);
    push_list('{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF});
    run_search("tgt_ff", 8'hFF, 0, 0, 9, 8'hFF, 1, 0);
    push_model(8'h01, c, r);
    run_search("tgt_01", 8'h01, 0, 0, c, r, 1, 0);
  endtask

  task automatic test_bad_flags;
    push_list('{8'h80});
    run_search("bad_flags", 8'h37, 1, 1, 2, 8'h80, 0, 1);
  endtask

  task automatic test_back_to_back;
    int c;
    logic [7:0] r, t;
    for (int i = 0; i < 6; i++) begin
      t = 8'($urandom_range(0, 255));
      push_model(t, c, r);
      run_search("random", t, 0, i[0], c, r, 1, 0);
      total++;
      if (r !== t) begin
        bad++;
        $display("FAIL model_result: got %h want %h", r, t);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] l[$] = '{8'h80, 8'h40, 8'h20, 8'h30};
    bit saw_done = 0;
    tgt = 8'h33;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (trial !== l[c]) begin
        bad++;
        $display("FAIL mid_reset trial c%0d: got %h want %h", c + 1, trial, l[c]);
      end
      if (c < 3) @(negedge clk);
    end
    #2 rst = 1;
    #1;
    total++;
    if ({trial, busy, done, result, found, error} !== '0) begin
      bad++;
      $display("FAIL mid_reset outputs: got %h/%b/%b/%h/%b/%b want all 0", trial, busy, done, result, found, error);
    end
    @(negedge clk) rst = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL mid_reset no_done: got activity after abort, want none");
    end
    push_list('{8'h80, 8'h40, 8'h20, 8'h30, 8'h38, 8'h34, 8'h32, 8'h33});
    run_search("after_reset", 8'h33, 0, 0, 9, 8'h33, 1, 0);
  endtask

  initial begin
    test_reset;
    test_plan_vectors;
    test_bad_flags;
    test_back_to_back;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation search controller: the initiator side of an N-bit magnitude comparator.
- It drives a trial operand into the comparator and consumes the comparator's greater/lesser/equal flags. From those flags it binary-searches the unknown target value held on the comparator's other operand.
- Used wherever a value must be recovered through compare-only access (threshold search, ADC-style conversion).

Parameters:
- N, 8, operand width in bits (N >= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin a search; accepted only in IDLE.
- cmp_greater  in  1  comparator flag: target > trial.
- cmp_lesser  in  1  comparator flag: target < trial.
- cmp_equal  in  1  comparator flag: target == trial.
- trial  out  N  registered operand driven to the comparator.
- busy  out  1  high from the cycle after start acceptance until DONE is left.
- done  out  1  one-cycle pulse; result, found and error are valid in this cycle and afterwards.
- result  out  N  recovered value; held until the next accepted start.
- found  out  1  search ended with a confirmed equal.
- error  out  1  illegal comparator flags seen (not exactly one-hot).

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous, active-high.
- Reset value of all outputs is 0; state is IDLE; internal accumulator acc = 0; bit pointer = N-1.
- The comparator is combinational. trial is registered, and the flags are sampled at the clock edge ending each TEST/VERIFY cycle.
- States: IDLE, TEST, VERIFY, DONE.
- IDLE:
  - trial = 0, busy = 0.
  - start = 1 -> clear acc, found and error; ptr = N-1; go to TEST.
- TEST:
  - trial = acc | (1 << ptr); busy = 1.
  - Flags not exactly one-hot -> error = 1, result = trial, go to DONE.
  - cmp_equal -> result = trial, found = 1, go to DONE (early exit).
  - cmp_greater -> acc[ptr] = 1.
  - cmp_lesser -> acc[ptr] = 0.
  - If ptr == 0 -> go to VERIFY; otherwise ptr decrements and the state stays TEST.
- VERIFY (reached only when no equal was seen, e.g. target = 0):
  - trial = acc.
  - cmp_equal only -> found = 1.
  - Any other flag pattern -> error = 1.
  - result = acc; go to DONE.
- DONE:
  - done = 1 for exactly one cycle; busy = 1.
  - Next state IDLE; trial returns to 0 in IDLE.
- Latency from start edge to done: at most N TEST cycles + 1 VERIFY + 1 DONE = N+2 cycles. Early equal at bit k shortens this to (N-k) TEST cycles + 1.
- start while busy, including the DONE cycle, is ignored with no side effects.
- rst mid-search aborts immediately to the reset values; no done pulse is issued.
- found and error are mutually exclusive and never both 1.
- Arithmetic: bitwise only, no carries; ptr width is clog2(N).

Decomposition:
- Shared package sar_pkg:
  - state encoding localparams ST_IDLE = 2'd0, ST_TEST = 2'd1, ST_VERIFY = 2'd2, ST_DONE = 2'd3.
  - flag one-hot check function.
- Sub-modules: none inside the block; a single FSM + datapath is natural.
- The bench pairs the block with the team's N-bit comparator module: target on operand a, trial on operand b.

Test Plan:
- Target 0xA5, start pulse (N = 8):
  - trials must run 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - equal on the 8th TEST; done with result = 0xA5, found = 1, error = 0.
  - done 9 cycles after the start edge.
- Target 0x40:
  - trials 0x80 (lesser), 0x40 (equal).
  - done 3 cycles after start; result = 0x40, found = 1.
- Target 0x00:
  - all 8 TESTs lesser, then VERIFY with trial 0x00 and equal.
  - done at cycle 10; result = 0x00, found = 1.
- Target 0xFF:
  - all greater until trial 0xFF, which returns equal; result = 0xFF, found = 1.
- Forced flags greater = lesser = 1 on the first TEST:
  - error = 1, found = 0, result = 0x80, done on the next cycle.
  - A start pulse during busy is ignored.
- Reset mid-search:
  - assert rst during the 4th TEST; all outputs 0 immediately (asynchronous), no done pulse.
  - A new start then completes normally.
